// File: rtl/dac_cal_sequencer.sv
// DAC calibration sequencer: forces alternating HI/LO codes onto the codec output,
// waits for the analog path to settle, averages one ADC channel and reports each result.
module dac_cal_sequencer #(
    parameter int W              = 16,
    parameter int SETPOINT_HI    = 20000,
    parameter int SETPOINT_LO    = -20000,
    parameter int N_ROUNDS       = 4,
    parameter int SETTLE_SAMPLES = 4096,
    parameter int AVG_LOG2       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_fs,
    input  logic                start,
    input  logic                abort,
    input  logic signed [W-1:0] adc_in,
    output logic                force_en,
    output logic signed [W-1:0] force_dac_output,
    output logic                busy,
    output logic                done,
    output logic                meas_valid,
    input  logic                meas_ready,
    output logic                meas_point,
    output logic [7:0]          meas_round,
    output logic signed [W-1:0] meas_avg
);

    localparam int AW  = W + AVG_LOG2;
    localparam int CW  = AVG_LOG2 + 1;
    localparam int SCW = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES);
    localparam logic signed [W-1:0] HI_CODE = W'(SETPOINT_HI);
    localparam logic signed [W-1:0] LO_CODE = W'(SETPOINT_LO);
    localparam logic [CW-1:0]  AVG_LAST    = CW'((1 << AVG_LOG2) - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
    localparam logic [7:0]     LAST_ROUND  = 8'(N_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_ACCUM, S_REPORT, S_DONE
    } state_t;

    state_t state, state_next;
    logic                 point, point_next;
    logic [7:0]           round, round_next;
    logic [SCW-1:0]       settle_cnt;
    logic [CW-1:0]        avg_cnt;
    logic signed [AW-1:0] acc, acc_next;
    logic                 accum_done, active_next;
    logic                 rst_q1, rst_sync_n;
    logic                 fs_meta, fs_sync, fs_prev, tick;

    // Reset asserts asynchronously but releases in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q1     <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_q1     <= 1'b1;
            rst_sync_n <= rst_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            fs_meta <= 1'b0;
            fs_sync <= 1'b0;
            fs_prev <= 1'b0;
        end else begin
            fs_meta <= clk_fs;
            fs_sync <= fs_meta;
            fs_prev <= fs_sync;
        end
    end

    assign tick = fs_sync & ~fs_prev;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= S_IDLE;
            point <= 1'b0;
            round <= 8'd0;
        end else begin
            state <= state_next;
            point <= point_next;
            round <= round_next;
        end
    end

    always_comb begin
        state_next = state;
        point_next = point;
        round_next = round;
        acc_next   = acc + AW'(adc_in);
        accum_done = (state == S_ACCUM) && tick && (avg_cnt == AVG_LAST);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_SETTLE;
                    point_next = 1'b0;
                    round_next = 8'd0;
                end
            end
            S_SETTLE: begin
                if (SETTLE_SAMPLES == 0 || (tick && settle_cnt == SETTLE_LAST))
                    state_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (accum_done) state_next = S_REPORT;
            end
            S_REPORT: begin
                if (meas_ready) begin
                    if (!point) begin
                        point_next = 1'b1;
                        state_next = S_SETTLE;
                    end else if (round < LAST_ROUND) begin
                        round_next = round + 8'd1;
                        point_next = 1'b0;
                        state_next = S_SETTLE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_next = S_IDLE;
        active_next = (state_next == S_SETTLE) || (state_next == S_ACCUM) ||
                      (state_next == S_REPORT);
    end

    // Outputs follow the next state, so they only move on state transitions.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            force_en         <= 1'b0;
            force_dac_output <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            meas_valid       <= 1'b0;
            meas_point       <= 1'b0;
            meas_round       <= 8'd0;
            meas_avg         <= '0;
            settle_cnt       <= '0;
            avg_cnt          <= '0;
            acc              <= '0;
        end else begin
            force_en         <= active_next;
            busy             <= active_next;
            force_dac_output <= !active_next ? '0 : (point_next ? LO_CODE : HI_CODE);
            done             <= (state_next == S_DONE);
            meas_valid       <= (state_next == S_REPORT);

            if (state != S_SETTLE)  settle_cnt <= '0;
            else if (tick)          settle_cnt <= settle_cnt + SCW'(1);

            // Accumulator stays cleared outside ACCUM, including after each accept.
            if (state != S_ACCUM) begin
                avg_cnt <= '0;
                acc     <= '0;
            end else if (tick) begin
                avg_cnt <= avg_cnt + CW'(1);
                acc     <= acc_next;
            end

            if (accum_done) begin
                meas_avg   <= W'(acc_next >>> AVG_LOG2);
                meas_point <= point;
                meas_round <= round;
            end
        end
    end

endmodule

// File: tb/tb_dac_cal_sequencer.sv
// Directed bench for dac_cal_sequencer: two instances cover the long-settle single-round
// configuration and the zero-settle three-round configuration.
module tb_dac_cal_sequencer;

    logic clk = 1'b0;
    logic clk_fs = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic signed [15:0] adc_in = 16'sd0;
    logic signed [15:0] adc_const = 16'sd1000;
    bit   adc_mode = 1'b0;
    int   pat_idx = 0;
    logic signed [15:0] pat [4] = '{-16'sd3, -16'sd2, -16'sd2, -16'sd2};

    logic               a_force_en, a_busy, a_done, a_valid, a_point;
    logic signed [15:0] a_dac, a_avg;
    logic [7:0]         a_round;
    logic               b_force_en, b_busy, b_done, b_valid, b_point;
    logic signed [15:0] b_dac, b_avg;
    logic [7:0]         b_round;

    int errors = 0;
    int checks = 0;
    int a_done_cnt = 0;
    int b_meas_cnt = 0;

    always #5 clk = ~clk;
    always #40 clk_fs = ~clk_fs;

    // A period-4 pattern makes any 4 consecutive samples sum to -9, whatever the alignment.
    always @(negedge clk_fs) begin
        if (adc_mode) begin
            adc_in = pat[pat_idx];
            pat_idx = (pat_idx + 1) % 4;
        end else begin
            adc_in = adc_const;
        end
    end

    always @(negedge clk) begin
        if (a_done) a_done_cnt++;
        if (b_valid && ready_b) b_meas_cnt++;
    end

    dac_cal_sequencer #(
        .W(16), .SETPOINT_HI(20000), .SETPOINT_LO(-20000),
        .N_ROUNDS(1), .SETTLE_SAMPLES(8), .AVG_LOG2(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_fs(clk_fs), .start(start_a), .abort(abort),
        .adc_in(adc_in), .force_en(a_force_en), .force_dac_output(a_dac), .busy(a_busy),
        .done(a_done), .meas_valid(a_valid), .meas_ready(ready_a), .meas_point(a_point),
        .meas_round(a_round), .meas_avg(a_avg)
    );

    dac_cal_sequencer #(
        .W(16), .SETPOINT_HI(20000), .SETPOINT_LO(-20000),
        .N_ROUNDS(3), .SETTLE_SAMPLES(0), .AVG_LOG2(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_fs(clk_fs), .start(start_b), .abort(abort),
        .adc_in(adc_in), .force_en(b_force_en), .force_dac_output(b_dac), .busy(b_busy),
        .done(b_done), .meas_valid(b_valid), .meas_ready(ready_b), .meas_point(b_point),
        .meas_round(b_round), .meas_avg(b_avg)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic wait_valid(input bit use_b, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (use_b ? b_valid : a_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid_timeout"}, int'(seen), 1);
    endtask

    task automatic wait_done(input bit use_b, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (use_b ? b_done : a_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_timeout"}, int'(seen), 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        int done_before;
        int unstable;
        logic signed [15:0] held_avg;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_force_en", a_force_en, 0);
        check("rst_dac", a_dac, 0);
        check("rst_busy", a_busy, 0);
        check("rst_valid", a_valid, 0);
        check("rst_done", a_done, 0);
        check("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic single-round run with constant input
        ready_a = 1'b1;
        @(negedge clk);
        pulse_start_a();
        check("t1_busy", a_busy, 1);
        check("t1_force_en", a_force_en, 1);
        check("t1_dac_hi", a_dac, 20000);
        wait_valid(1'b0, "t1_m0");
        check("t1_m0_avg", a_avg, 1000);
        check("t1_m0_point", a_point, 0);
        check("t1_m0_round", a_round, 0);
        check("t1_m0_dac", a_dac, 20000);
        @(negedge clk);
        check("t1_valid_drop", a_valid, 0);
        check("t1_dac_lo", a_dac, -20000);
        wait_valid(1'b0, "t1_m1");
        check("t1_m1_avg", a_avg, 1000);
        check("t1_m1_point", a_point, 1);
        check("t1_m1_round", a_round, 0);
        @(negedge clk);
        check("t1_done", a_done, 1);
        check("t1_done_busy", a_busy, 0);
        check("t1_done_force_en", a_force_en, 0);
        check("t1_done_dac", a_dac, 0);
        @(negedge clk);
        check("t1_done_drop", a_done, 0);
        check("t1_idle_valid", a_valid, 0);
        check("t1_done_count", a_done_cnt, 1);

        // Rounding toward -inf, with ready held low for 500 cycles
        adc_mode = 1'b1;
        ready_a = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start_a();
        wait_valid(1'b0, "t2_m0");
        check("t2_m0_avg", a_avg, -3);
        check("t2_m0_point", a_point, 0);
        held_avg = a_avg;
        unstable = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (a_valid !== 1'b1 || a_avg !== held_avg || a_dac !== 16'sd20000 ||
                a_point !== 1'b0)
                unstable++;
        end
        check("t2_hold_unstable", unstable, 0);
        ready_a = 1'b1;
        @(negedge clk);
        check("t2_valid_drop", a_valid, 0);
        check("t2_dac_lo", a_dac, -20000);
        wait_valid(1'b0, "t2_m1");
        check("t2_m1_avg", a_avg, -3);
        check("t2_m1_point", a_point, 1);
        wait_done(1'b0, "t2");

        // Abort during the second settle
        adc_mode = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start_a();
        wait_valid(1'b0, "t3_m0");
        @(negedge clk);
        check("t3_dac_lo", a_dac, -20000);
        repeat (24) @(negedge clk);
        done_before = a_done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_abort_force_en", a_force_en, 0);
        check("t3_abort_dac", a_dac, 0);
        check("t3_abort_busy", a_busy, 0);
        check("t3_abort_valid", a_valid, 0);
        repeat (100) @(negedge clk);
        check("t3_no_done", a_done_cnt, done_before);
        check("t3_still_idle", a_busy, 0);
        pulse_start_a();
        check("t3_restart_dac", a_dac, 20000);
        wait_valid(1'b0, "t3_r0");
        check("t3_restart_point", a_point, 0);
        check("t3_restart_round", a_round, 0);
        wait_done(1'b0, "t3");

        // Start and abort together from IDLE
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort = 1'b0;
        check("t4_both_busy", a_busy, 0);
        check("t4_both_force_en", a_force_en, 0);
        repeat (3) @(negedge clk);
        check("t4_both_busy_later", a_busy, 0);

        // Start while busy is ignored
        ready_a = 1'b0;
        pulse_start_a();
        wait_valid(1'b0, "t5_m0");
        pulse_start_a();
        check("t5_valid_held", a_valid, 1);
        check("t5_point_held", a_point, 0);
        check("t5_round_held", a_round, 0);
        ready_a = 1'b1;
        @(negedge clk);
        check("t5_dac_lo", a_dac, -20000);
        wait_valid(1'b0, "t5_m1");
        check("t5_m1_point", a_point, 1);
        wait_done(1'b0, "t5");

        // Three rounds, zero settle
        ready_b = 1'b1;
        repeat (5) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t6_busy", b_busy, 1);
        for (int i = 0; i < 6; i++) begin
            wait_valid(1'b1, $sformatf("t6_m%0d", i));
            check($sformatf("t6_m%0d_round", i), b_round, i / 2);
            check($sformatf("t6_m%0d_point", i), b_point, i % 2);
            check($sformatf("t6_m%0d_avg", i), b_avg, 1000);
        end
        wait_done(1'b1, "t6");
        repeat (50) @(negedge clk);
        check("t6_meas_count", b_meas_cnt, 6);
        check("t6_idle_busy", b_busy, 0);

        // Async reset mid-accumulation
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (10) @(negedge clk);
        check("t7_force_en_pre", b_force_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_force_en", b_force_en, 0);
        check("t7_rst_dac", b_dac, 0);
        check("t7_rst_busy", b_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t7_post_busy", b_busy, 0);
        check("t7_post_valid", b_valid, 0);
        check("t7_post_round", b_round, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
